// File: rtl/pixel_write_master_pkg.sv
// Shared AXI4-Lite response codes, protection constant and write-FSM state encodings
// for the pixel write master.
package pixel_write_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, non-secure, data access.
    localparam logic [2:0] AWPROT_DATA = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pixel_write_master_if.sv
// Pixel stream, AXI4-Lite write channels and error/interrupt sideband of the pixel write master.
// The master modport is the write master's view; slave is the environment's view.
interface pixel_write_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   iPIX_ADDR;
    logic [DATA_WIDTH-1:0]   iPIX_DATA;
    logic                    iPIX_LAST;
    logic                    iPIX_VALID;
    logic                    oPIX_READY;

    logic [ADDR_WIDTH-1:0]   oAWADDR;
    logic [2:0]              oAWPROT;
    logic                    oAWVALID;
    logic                    oAWREADY;

    logic [DATA_WIDTH-1:0]   oWDATA;
    logic [DATA_WIDTH/8-1:0] oWSTRB;
    logic                    oWVALID;
    logic                    oWREADY;

    logic [1:0]              oBRESP;
    logic                    oBVALID;
    logic                    oBREADY;

    logic                    iERR_CLR;
    logic                    oERR;
    logic [7:0]              oERR_CNT;
    logic                    RenderEndInterrupt;

    modport master (
        input  iPIX_ADDR, iPIX_DATA, iPIX_LAST, iPIX_VALID,
        output oPIX_READY,
        output oAWADDR, oAWPROT, oAWVALID,
        input  oAWREADY,
        output oWDATA, oWSTRB, oWVALID,
        input  oWREADY,
        input  oBRESP, oBVALID,
        output oBREADY,
        input  iERR_CLR,
        output oERR, oERR_CNT, RenderEndInterrupt
    );

    modport slave (
        output iPIX_ADDR, iPIX_DATA, iPIX_LAST, iPIX_VALID,
        input  oPIX_READY,
        input  oAWADDR, oAWPROT, oAWVALID,
        output oAWREADY,
        input  oWDATA, oWSTRB, oWVALID,
        output oWREADY,
        output oBRESP, oBVALID,
        input  oBREADY,
        output iERR_CLR,
        input  oERR, oERR_CNT, RenderEndInterrupt
    );

endinterface

// File: rtl/pixel_write_master_fifo.sv
// First-word-fall-through synchronous FIFO, 2^AW entries; dout valid whenever !empty.
// Pushes while full and pops while empty are ignored.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_master.sv
// Buffers pixel writes and drains them as single AXI4-Lite writes, one outstanding; 2-cycle
// push-to-AWVALID latency. oPIX_READY drops when the FIFO is full or reset is asserted.
module pixel_write_master
    import pixel_write_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_AW    = 3
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    pixel_write_master_if.master bus
);

    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0]    w_fifo_din;
    logic [ENTRY_W-1:0]    w_fifo_dout;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pix_rdy;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic                  w_resp_err;

    state_t                r_state;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_last;
    logic                  r_irq;
    logic                  r_err;
    logic [7:0]            r_err_cnt;

    assign w_pix_rdy  = ~w_full & ~ARESET;
    assign w_push     = bus.iPIX_VALID & w_pix_rdy;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
    assign w_fifo_din = {bus.iPIX_LAST, bus.iPIX_ADDR, bus.iPIX_DATA};

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // A channel counts as done if it already completed or completes on this edge.
    assign w_aw_done  = ~r_awvalid | bus.oAWREADY;
    assign w_w_done   = ~r_wvalid | bus.oWREADY;
    assign w_resp_err = (r_state == ST_RESP) & r_bready & bus.oBVALID & (bus.oBRESP != RESP_OKAY);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_last    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        {r_last, r_awaddr, r_wdata} <= w_fifo_dout;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_awvalid && bus.oAWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && bus.oWREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.oBVALID) begin
                        r_bready <= 1'b0;
                        r_irq    <= r_last;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A clear in the same cycle as an error response takes priority.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (bus.iERR_CLR) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_resp_err) begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc8(r_err_cnt);
        end
    end

    assign bus.oPIX_READY         = w_pix_rdy;
    assign bus.oAWADDR            = r_awaddr;
    assign bus.oAWPROT            = AWPROT_DATA;
    assign bus.oAWVALID           = r_awvalid;
    assign bus.oWDATA             = r_wdata;
    assign bus.oWSTRB             = '1;
    assign bus.oWVALID            = r_wvalid;
    assign bus.oBREADY            = r_bready;
    assign bus.oERR               = r_err;
    assign bus.oERR_CNT           = r_err_cnt;
    assign bus.RenderEndInterrupt = r_irq;

endmodule

// File: tb/tb_pixel_write_master.sv
// Directed bench for pixel_write_master: reset values, latency, skewed handshakes, fill,
// error counting/clear/saturation and mid-transaction reset.
module tb_pixel_write_master;
    import pixel_write_master_pkg::*;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    pixel_write_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    pixel_write_master #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .FIFO_AW    (3)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int n_aw  = 0;
    int n_b   = 0;
    int n_irq = 0;

    logic [7:0]  aw_q[$];
    logic [31:0] w_q[$];
    logic [3:0]  strb_q[$];
    logic [7:0]  exp_a_q[$];
    logic [31:0] exp_d_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: records every completed handshake and every interrupt-high cycle.
    always @(posedge ACLK) begin
        if (!ARESET) begin
            if (bus.oAWVALID && bus.oAWREADY) begin
                aw_q.push_back(bus.oAWADDR);
                n_aw++;
            end
            if (bus.oWVALID && bus.oWREADY) begin
                w_q.push_back(bus.oWDATA);
                strb_q.push_back(bus.oWSTRB);
            end
            if (bus.oBVALID && bus.oBREADY) n_b++;
            if (bus.RenderEndInterrupt) n_irq++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_pix(input logic [7:0] a, input logic [31:0] d, input logic l);
        int g = 0;
        bus.iPIX_ADDR  = a;
        bus.iPIX_DATA  = d;
        bus.iPIX_LAST  = l;
        bus.iPIX_VALID = 1'b1;
        while (!bus.oPIX_READY && g < 300) begin
            @(negedge ACLK);
            g++;
        end
        if (g >= 300) check_val("push_timeout", 64'(g), 0);
        else begin
            exp_a_q.push_back(a);
            exp_d_q.push_back(d);
        end
        @(negedge ACLK);
        bus.iPIX_VALID = 1'b0;
    endtask

    task automatic wait_b(input int target);
        int g = 0;
        while (n_b < target && g < 200) begin
            @(negedge ACLK);
            g++;
        end
        if (n_b < target) check_val("bresp_timeout", 64'(n_b), 64'(target));
        repeat (2) @(negedge ACLK);
    endtask

    task automatic wait_awvalid();
        int g = 0;
        while (!bus.oAWVALID && g < 50) begin
            @(negedge ACLK);
            g++;
        end
        if (g >= 50) check_val("awvalid_timeout", 64'(g), 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic l,
                            input logic [1:0] resp);
        int t;
        t = n_b + 1;
        bus.oBRESP = resp;
        push_pix(a, d, l);
        wait_b(t);
    endtask

    task automatic flush_q();
        aw_q.delete(); w_q.delete(); strb_q.delete();
        exp_a_q.delete(); exp_d_q.delete();
    endtask

    task automatic check_drain(input string tag);
        check_val({tag, "_aw_cnt"}, 64'(aw_q.size()), 64'(exp_a_q.size()));
        check_val({tag, "_w_cnt"},  64'(w_q.size()),  64'(exp_d_q.size()));
        for (int i = 0; i < exp_a_q.size() && i < aw_q.size(); i++)
            check_val($sformatf("%s_addr%0d", tag, i), 64'(aw_q[i]), 64'(exp_a_q[i]));
        for (int i = 0; i < exp_d_q.size() && i < w_q.size(); i++) begin
            check_val($sformatf("%s_data%0d", tag, i), 64'(w_q[i]), 64'(exp_d_q[i]));
            check_val($sformatf("%s_strb%0d", tag, i), 64'(strb_q[i]), 64'h0F);
        end
        flush_q();
    endtask

    int irq0;
    int b0;
    logic [1:0] err_resps [5];

    initial begin
        bus.iPIX_ADDR  = '0;
        bus.iPIX_DATA  = '0;
        bus.iPIX_LAST  = 1'b0;
        bus.iPIX_VALID = 1'b0;
        bus.oAWREADY   = 1'b0;
        bus.oWREADY    = 1'b0;
        bus.oBVALID    = 1'b0;
        bus.oBRESP     = RESP_OKAY;
        bus.iERR_CLR   = 1'b0;
        err_resps[0] = RESP_OKAY;   err_resps[1] = RESP_SLVERR; err_resps[2] = RESP_OKAY;
        err_resps[3] = RESP_SLVERR; err_resps[4] = RESP_OKAY;

        // Reset values
        repeat (3) @(negedge ACLK);
        check_val("rst_awvalid", bus.oAWVALID, 0);
        check_val("rst_wvalid",  bus.oWVALID, 0);
        check_val("rst_bready",  bus.oBREADY, 0);
        check_val("rst_awaddr",  bus.oAWADDR, 0);
        check_val("rst_wdata",   bus.oWDATA, 0);
        check_val("rst_wstrb",   bus.oWSTRB, 64'h0F);
        check_val("rst_awprot",  bus.oAWPROT, 64'h2);
        check_val("rst_pixrdy",  bus.oPIX_READY, 0);
        check_val("rst_err",     bus.oERR, 0);
        check_val("rst_errcnt",  bus.oERR_CNT, 0);
        check_val("rst_irq",     bus.RenderEndInterrupt, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check_val("post_rst_pixrdy", bus.oPIX_READY, 1);

        // Single pixel, zero-wait slave, with push-to-valid latency
        bus.oAWREADY = 1'b1; bus.oWREADY = 1'b1; bus.oBVALID = 1'b1;
        irq0 = n_irq; b0 = n_b;
        push_pix(8'h10, 32'hDEADBEEF, 1'b1);
        check_val("lat_awvalid_early", bus.oAWVALID, 0);
        @(negedge ACLK);
        check_val("lat_awvalid", bus.oAWVALID, 1);
        check_val("lat_wvalid",  bus.oWVALID, 1);
        check_val("lat_awaddr",  bus.oAWADDR, 64'h10);
        check_val("lat_wdata",   bus.oWDATA, 64'hDEADBEEF);
        wait_b(b0 + 1);
        check_drain("single");
        check_val("single_irq", 64'(n_irq - irq0), 1);

        // Skewed handshake: W completes well before AW
        bus.oAWREADY = 1'b0; bus.oWREADY = 1'b0; bus.oBVALID = 1'b0;
        b0 = n_b;
        push_pix(8'h44, 32'h12345678, 1'b0);
        wait_awvalid();
        check_val("skew_awaddr0", bus.oAWADDR, 64'h44);
        bus.oWREADY = 1'b1;
        @(negedge ACLK);
        bus.oWREADY = 1'b0;
        check_val("skew_wvalid_drop", bus.oWVALID, 0);
        check_val("skew_awvalid_held", bus.oAWVALID, 1);
        repeat (2) @(negedge ACLK);
        check_val("skew_awvalid_held2", bus.oAWVALID, 1);
        check_val("skew_awaddr_stable", bus.oAWADDR, 64'h44);
        check_val("skew_bready_low", bus.oBREADY, 0);
        bus.oAWREADY = 1'b1;
        @(negedge ACLK);
        bus.oAWREADY = 1'b0;
        check_val("skew_awvalid_drop", bus.oAWVALID, 0);
        check_val("skew_bready_high", bus.oBREADY, 1);
        bus.oBVALID = 1'b1;
        @(negedge ACLK);
        bus.oBVALID = 1'b0;
        check_val("skew_bready_drop", bus.oBREADY, 0);
        check_val("skew_b_cnt", 64'(n_b - b0), 1);
        check_drain("skew");

        // Fill: first pixel sits in the output registers, eight more fill the FIFO
        bus.oAWREADY = 1'b0; bus.oWREADY = 1'b1; bus.oBVALID = 1'b1;
        irq0 = n_irq; b0 = n_b;
        for (int i = 0; i < 9; i++)
            push_pix(8'h20 + 8'(i), 32'hA000_0000 + 32'(i), (i == 8));
        repeat (2) @(negedge ACLK);
        check_val("fill_pixrdy_full", bus.oPIX_READY, 0);
        check_val("fill_awaddr_head", bus.oAWADDR, 64'h20);
        bus.oAWREADY = 1'b1;
        wait_b(b0 + 9);
        check_val("fill_pixrdy_back", bus.oPIX_READY, 1);
        check_drain("fill");
        check_val("fill_irq", 64'(n_irq - irq0), 1);

        // Errors: 2 SLVERR out of 5 writes, no interrupt for non-last pixels
        irq0 = n_irq;
        for (int i = 0; i < 5; i++)
            do_write(8'h60 + 8'(i), 32'(i), 1'b0, err_resps[i]);
        check_val("err_flag", bus.oERR, 1);
        check_val("err_cnt2", bus.oERR_CNT, 2);
        check_val("err_no_irq", 64'(n_irq - irq0), 0);

        // Clear on the very edge of a third error response
        bus.oBVALID = 1'b0;
        bus.oBRESP  = RESP_SLVERR;
        push_pix(8'h70, 32'h7070, 1'b0);
        begin
            int g = 0;
            while (!bus.oBREADY && g < 50) begin @(negedge ACLK); g++; end
            if (g >= 50) check_val("clr_bready_timeout", 64'(g), 0);
        end
        check_val("clr_cnt_before", bus.oERR_CNT, 2);
        bus.oBVALID = 1'b1; bus.iERR_CLR = 1'b1;
        @(negedge ACLK);
        bus.oBVALID = 1'b0; bus.iERR_CLR = 1'b0;
        @(negedge ACLK);
        check_val("clr_cnt", bus.oERR_CNT, 0);
        check_val("clr_flag", bus.oERR, 0);

        // Interrupt still fires for a last pixel with an error response
        bus.oBVALID = 1'b1;
        irq0 = n_irq;
        do_write(8'h71, 32'h7171, 1'b1, RESP_SLVERR);
        check_val("errlast_irq", 64'(n_irq - irq0), 1);
        check_val("errlast_cnt", bus.oERR_CNT, 1);
        check_drain("err");

        // Saturation
        bus.iERR_CLR = 1'b1;
        @(negedge ACLK);
        bus.iERR_CLR = 1'b0;
        for (int i = 0; i < 260; i++)
            do_write(8'(i), 32'(i) ^ 32'h5A5A_0000, 1'b0, RESP_DECERR);
        check_val("sat_cnt", bus.oERR_CNT, 255);
        check_val("sat_flag", bus.oERR, 1);
        check_drain("sat");

        // Reset with a transaction in SEND and two pixels queued
        bus.oAWREADY = 1'b0; bus.oWREADY = 1'b0; bus.oBVALID = 1'b0;
        bus.oBRESP = RESP_OKAY;
        for (int i = 0; i < 3; i++)
            push_pix(8'h80 + 8'(i), 32'hC0 + 32'(i), 1'b0);
        wait_awvalid();
        ARESET = 1'b1;
        #1;
        check_val("mrst_awvalid", bus.oAWVALID, 0);
        check_val("mrst_wvalid",  bus.oWVALID, 0);
        check_val("mrst_bready",  bus.oBREADY, 0);
        check_val("mrst_pixrdy",  bus.oPIX_READY, 0);
        check_val("mrst_errcnt",  bus.oERR_CNT, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        flush_q();
        bus.oAWREADY = 1'b1; bus.oWREADY = 1'b1; bus.oBVALID = 1'b1;
        b0 = n_aw;
        repeat (5) @(negedge ACLK);
        check_val("mrst_fifo_empty", 64'(n_aw - b0), 0);
        check_val("mrst_idle_awvalid", bus.oAWVALID, 0);
        check_val("mrst_pixrdy_back", bus.oPIX_READY, 1);
        irq0 = n_irq; b0 = n_b;
        push_pix(8'h90, 32'h9090_9090, 1'b1);
        @(negedge ACLK);
        check_val("mrst_lat_awvalid", bus.oAWVALID, 1);
        wait_b(b0 + 1);
        check_drain("mrst");
        check_val("mrst_irq", 64'(n_irq - irq0), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
